muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencing controller for the EX-stage multiply/divide resources and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from EX and drives the external fixed-latency multiplier and the start/ready iterative divider. It raises the EX stall request for the whole operation, commits results to HI/LO, and handles flush and hold interactions with the pipeline.

## Interface
Parameters:
- MUL_LAT, 2: cycles from operands presented to mul_result valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- op_valid  in  1  EX holds a mul/div/HI-LO-write op; held stable by EX while stallreq=1.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved (ignored).
- src1, src2  in  32  operands (rs, rt).
- ex_hold  in  1  EX instruction will not advance at the next edge (stall from elsewhere).
- flush  in  1  abort the current op.
- mul_signed  out  1;  mul_a, mul_b  out  32  multiplier controls.
- mul_result  in  64  multiplier product.
- div_start, div_signed, div_annul  out  1;  div_op1, div_op2  out  32  divider controls.
- div_result  in  64  {remainder, quotient};  div_ready  in  1  one-cycle done pulse.
- hi_o, lo_o  out  32  registered HI/LO.
- hilo_we  out  1  HI/LO update pulse (same cycle as the commit).
- stallreq  out  1  to the stall controller; holds IF..EX.

## Operation
- States: IDLE, MUL_BUSY, DIV_BUSY, HOLD. A 4-bit down-counter cnt and latched operands/sign are kept internally.
- IDLE, op_valid, !flush:
  - MULT/MULTU: latch src1/src2 and sign; cnt<=MUL_LAT-1; go to MUL_BUSY; stallreq=1.
  - DIV/DIVU: div_start=1; latch operands/sign; go to DIV_BUSY; stallreq=1.
  - MTHI/MTLO: write src1 into HI/LO at the edge, hilo_we=1, no stall. Repeated writes under ex_hold are permitted (idempotent).
- Operand muxing: in IDLE, mul_*/div_op* come combinationally from src1/src2. In the busy states they come from the latched values. Signed = op[0]==0.
- MUL_BUSY:
  - cnt!=0: decrement, stallreq=1.
  - cnt==0: completion cycle. HI<=mul_result[63:32], LO<=mul_result[31:0], hilo_we=1, stallreq=0.
- DIV_BUSY:
  - div_ready=0: div_start=1, stallreq=1.
  - div_ready=1: completion cycle. div_start=0, HI<=div_result[63:32], LO<=div_result[31:0], hilo_we=1, stallreq=0.
  - Divide-by-zero results are whatever the divider returns; no trap.
- After completion: go to HOLD if ex_hold=1, else to IDLE.
- HOLD: stallreq=0, op_valid ignored (the same instruction is still in EX). Stay while ex_hold=1; go to IDLE when ex_hold=0.
- flush (priority over everything):
  - Next state is IDLE; no HI/LO write and hilo_we=0 that cycle; stallreq=0.
  - div_annul=1 for that one cycle when in DIV_BUSY, or in IDLE issuing a DIV/DIVU.
- Reserved op codes: no state change, no write.

## Timing
- Reset (resetn=0 at an edge): state IDLE, HI=LO=0, cnt=0, latched operands 0.
- While resetn=0, every output is driven to 0: stallreq, div_start, div_annul, hilo_we, mul_*, div_*.
- MULT: stallreq=1 in the issue cycle plus MUL_LAT-1 busy cycles, i.e. MUL_LAT cycles total. Commit at the end of cycle MUL_LAT after issue. hi_o/lo_o show the new value the cycle after.
- DIV: stallreq=1 from the issue cycle until the cycle div_ready rises (exclusive). Commit on the div_ready edge.
- MTHI/MTLO: zero stall; visible on hi_o/lo_o the next cycle.
- stallreq and div_start are combinational from state and inputs. HI/LO, state, cnt and latches are registered.
- A flush in the completion cycle cancels the commit.
- resetn low mid-operation aborts without annul and clears HI/LO.

## Test plan
- MULT, MUL_LAT=2, src1=0xFFFFFFFE (-2), src2=3 -> stallreq high 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; hilo_we one pulse.
- MULTU, same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV, src1=-7, src2=2; div_ready modelled after 33 cycles returning {0xFFFFFFFF, 0xFFFFFFFD} -> div_start and stallreq high exactly 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFD; div_signed=1 throughout.
- DIVU, with flush asserted on busy cycle 10 -> div_annul one pulse, HI/LO unchanged, state IDLE, a new MULT accepted the next cycle.
- MULT completing with ex_hold=1 for 3 cycles while op_valid stays high -> HOLD for 3 cycles, no second issue, single hilo_we; then MTLO 0x1234 -> LO=0x1234 next cycle, stallreq never high.
- resetn=0 for one edge during DIV_BUSY -> next cycle state IDLE, HI=LO=0, stallreq=0, div_start=0.

Source files
------------

// File: rtl/muldiv_if.sv
// EX-stage multiply/divide bundle: EX op request, multiplier and divider controls,
// and the HI/LO view and stall request returned to the pipeline.
interface muldiv_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        ex_hold;
   logic        flush;
   logic        mul_signed;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic        div_annul;
   logic [31:0] div_op1;
   logic [31:0] div_op2;
   logic [63:0] div_result;
   logic        div_ready;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        hilo_we;
   logic        stallreq;

   modport slave (
      input  op_valid, op, src1, src2, ex_hold, flush, mul_result, div_result, div_ready,
      output mul_signed, mul_a, mul_b, div_start, div_signed, div_annul, div_op1, div_op2,
             hi_o, lo_o, hilo_we, stallreq
   );

   modport master (
      output op_valid, op, src1, src2, ex_hold, flush, mul_result, div_result, div_ready,
      input  mul_signed, mul_a, mul_b, div_start, div_signed, div_annul, div_op1, div_op2,
             hi_o, lo_o, hilo_we, stallreq
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences MULT/DIV/MTHI/MTLO through the external multiplier and divider,
// owns the HI/LO pair and requests EX stalls while an operation is in flight.
module muldiv_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic      clk,
   input  logic      resetn,
   muldiv_if.slave   bus
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

   typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, HOLD} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] a_reg, a_next;
   logic [31:0] b_reg, b_next;
   logic        sign_reg, sign_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic        we, stall, start, annul;
   logic        idle;
   logic [31:0] opnd_a, opnd_b;
   logic        opnd_sign;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sign_next  = sign_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      we         = 1'b0;
      stall      = 1'b0;
      start      = 1'b0;
      annul      = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (bus.op_valid) begin
               if (bus.flush) begin
                  // A flushed divide may already have been seen by the divider.
                  annul = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
               end else begin
                  case (bus.op)
                     OP_MULT, OP_MULTU: begin
                        a_next     = bus.src1;
                        b_next     = bus.src2;
                        sign_next  = ~bus.op[0];
                        cnt_next   = CNT_INIT;
                        state_next = MUL_BUSY;
                        stall      = 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        a_next     = bus.src1;
                        b_next     = bus.src2;
                        sign_next  = ~bus.op[0];
                        start      = 1'b1;
                        state_next = DIV_BUSY;
                        stall      = 1'b1;
                     end
                     OP_MTHI: begin
                        hi_next = bus.src1;
                        we      = 1'b1;
                     end
                     OP_MTLO: begin
                        lo_next = bus.src1;
                        we      = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         MUL_BUSY: begin
            if (bus.flush) begin
               state_next = IDLE;
            end else if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
               stall    = 1'b1;
            end else begin
               hi_next    = bus.mul_result[63:32];
               lo_next    = bus.mul_result[31:0];
               we         = 1'b1;
               state_next = bus.ex_hold ? HOLD : IDLE;
            end
         end
         DIV_BUSY: begin
            if (bus.flush) begin
               annul      = 1'b1;
               state_next = IDLE;
            end else if (!bus.div_ready) begin
               start = 1'b1;
               stall = 1'b1;
            end else begin
               hi_next    = bus.div_result[63:32];
               lo_next    = bus.div_result[31:0];
               we         = 1'b1;
               state_next = bus.ex_hold ? HOLD : IDLE;
            end
         end
         HOLD: begin
            // The finished instruction is still in EX; do not re-issue it.
            if (bus.flush || !bus.ex_hold) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         a_reg     <= '0;
         b_reg     <= '0;
         sign_reg  <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sign_reg  <= sign_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

   // Operands go straight through in the issue cycle, then come from the latches.
   assign idle      = (state_reg == IDLE);
   assign opnd_a    = idle ? bus.src1 : a_reg;
   assign opnd_b    = idle ? bus.src2 : b_reg;
   assign opnd_sign = idle ? ~bus.op[0] : sign_reg;

   assign bus.mul_signed = resetn & opnd_sign;
   assign bus.mul_a      = resetn ? opnd_a : '0;
   assign bus.mul_b      = resetn ? opnd_b : '0;
   assign bus.div_signed = resetn & opnd_sign;
   assign bus.div_op1    = resetn ? opnd_a : '0;
   assign bus.div_op2    = resetn ? opnd_b : '0;
   assign bus.div_start  = resetn & start;
   assign bus.div_annul  = resetn & annul;
   assign bus.hilo_we    = resetn & we;
   assign bus.stallreq   = resetn & stall;
   assign bus.hi_o       = resetn ? hi_reg : '0;
   assign bus.lo_o       = resetn ? lo_reg : '0;

endmodule
